// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame buffer arbiter: parameter defaults,
// state encoding, read-return source tags and a small saturation helper.
package fb_arb_pkg;

  // 128x128 gray frame buffer
  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 8;
  // processing-port wait cycles before it is forced onto the BRAM
  localparam int STARVE_LIM_DEF = 32;

  // last accepted source; IDLE when nothing was accepted
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_PROC = 2'd2
  } arb_state_e;

  // who owns the read data coming back from the BRAM
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_PROC = 2'd2
  } src_tag_e;

  // clamp an unsigned value into an 8-bit debug register
  function automatic logic [7:0] sat_u8(input int unsigned v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/fb_rd_return_pipe.sv
// Read-return path: carries the source tag of each accepted read alongside
// the BRAM access and steers mem_rdata to the owning port two cycles after
// acceptance. Clearing the tags on reset drops any reads still in flight.
module fb_rd_return_pipe
  import fb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  src_tag_e          acc_tag,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              proc_rvalid,
  output logic [DATA_W-1:0] proc_rdata
);

  // tag_issue_q: tag of the access on the BRAM port this cycle
  // tag_ret_q  : tag of the data arriving on mem_rdata this cycle
  src_tag_e tag_issue_q;
  src_tag_e tag_ret_q;

  // advance the tag pipeline one stage per cycle, in acceptance order
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_issue_q <= TAG_NONE;
      tag_ret_q   <= TAG_NONE;
    end else begin
      tag_issue_q <= acc_tag;
      tag_ret_q   <= tag_issue_q;
    end
  end

  // steer returning data to its owner; data reads as zero when not valid
  always_comb begin
    disp_rvalid = !reset && (tag_ret_q == TAG_DISP);
    proc_rvalid = !reset && (tag_ret_q == TAG_PROC);
    disp_rdata  = disp_rvalid ? mem_rdata : '0;
    proc_rdata  = proc_rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Two-port arbiter in front of a single-port frame buffer BRAM. The display
// port normally wins; the processing port is forced through once it has
// waited STARVE_LIM cycles. One access is issued per cycle, in order, so a
// write followed by a read to the same address naturally returns new data.
module frame_buffer_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        starve_cnt_max
);

  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STARVE_LIM);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        starve_max_q, starve_max_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              force_proc;
  src_tag_e          acc_tag;

  // grant decision: display first unless processing has hit its wait limit
  always_comb begin
    force_proc = proc_req && (wait_q == WAIT_LIM);
    proc_gnt   = !reset && proc_req && (force_proc || !disp_req);
    disp_gnt   = !reset && disp_req && !proc_gnt;
  end

  // next-state for the wait counter, peak tracker, state and BRAM command
  always_comb begin
    wait_d = wait_q;
    if (!proc_req || proc_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_LIM) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    starve_max_d = starve_max_q;
    if (32'(wait_q) > 32'(starve_max_q)) begin
      starve_max_d = sat_u8(32'(wait_q));
    end

    // next state depends only on this cycle's grant
    if (proc_gnt) begin
      state_d = ST_PROC;
    end else if (disp_gnt) begin
      state_d = ST_DISP;
    end else begin
      state_d = ST_IDLE;
    end

    mem_we_d    = proc_gnt && proc_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (proc_gnt) begin
      mem_addr_d = proc_addr;
      if (proc_we) begin
        mem_wdata_d = proc_wdata;
      end
    end else if (disp_gnt) begin
      mem_addr_d = disp_addr;
    end

    // writes return nothing, so they carry no tag
    acc_tag = TAG_NONE;
    if (disp_gnt) begin
      acc_tag = TAG_DISP;
    end else if (proc_gnt && !proc_we) begin
      acc_tag = TAG_PROC;
    end
  end

  // state machine and registered BRAM command, one stage after acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      starve_max_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      starve_max_q <= starve_max_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // the BRAM is enabled exactly when the previous cycle accepted something
  always_comb begin
    mem_en         = !reset && (state_q != ST_IDLE);
    mem_we         = !reset && mem_we_q;
    mem_addr       = mem_addr_q;
    mem_wdata      = mem_wdata_q;
    starve_cnt_max = starve_max_q;
  end

  fb_rd_return_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_return_pipe (
    .clock       (clock),
    .reset       (reset),
    .acc_tag     (acc_tag),
    .mem_rdata   (mem_rdata),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .proc_rvalid (proc_rvalid),
    .proc_rdata  (proc_rdata)
  );

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: a behavioural BRAM, directed scenarios and
// a randomized run, all compared against a per-cycle expectation schedule
// built from the arbitration and timing rules.
module tb_frame_buffer_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int LIM  = 32;
  localparam int MAXC = 4000;
  localparam int MSZ  = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          proc_req = 1'b0;
  logic          proc_we = 1'b0;
  logic [AW-1:0] proc_addr = '0;
  logic [DW-1:0] proc_wdata = '0;
  logic          proc_gnt;
  logic [DW-1:0] proc_rdata;
  logic          proc_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [7:0]    starve_cnt_max;

  always #5 clock = ~clock;

  frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clock          (clock),
    .reset          (reset),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rdata     (disp_rdata),
    .disp_rvalid    (disp_rvalid),
    .proc_req       (proc_req),
    .proc_we        (proc_we),
    .proc_addr      (proc_addr),
    .proc_wdata     (proc_wdata),
    .proc_gnt       (proc_gnt),
    .proc_rdata     (proc_rdata),
    .proc_rvalid    (proc_rvalid),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .starve_cnt_max (starve_cnt_max)
  );

  // single-port BRAM, read-first, one cycle read latency
  logic [DW-1:0] bram [0:MSZ-1];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  // reference: frame contents and what each cycle must show
  logic [DW-1:0] gold    [0:MSZ-1];
  bit            e_men   [0:MAXC+3];
  bit            e_mwe   [0:MAXC+3];
  logic [AW-1:0] e_maddr [0:MAXC+3];
  logic [DW-1:0] e_mwd   [0:MAXC+3];
  logic [DW-1:0] e_wold  [0:MAXC+3];
  bit            e_dv    [0:MAXC+3];
  logic [DW-1:0] e_dd    [0:MAXC+3];
  bit            e_pv    [0:MAXC+3];
  logic [DW-1:0] e_pd    [0:MAXC+3];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wait_m = 0;
  int smax_m = 0;
  bit last_dg = 1'b0;
  bit last_pg = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  // one clock cycle: entered in the low phase with inputs already driven
  task automatic tick();
    bit dg, pg;
    #1;
    if (cyc >= MAXC) begin
      n_bad++;
      $display("FAIL cycle_budget got=%0d want<%0d", cyc, MAXC);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
    if (reset) begin
      // a write that was due on the BRAM this cycle never happens
      if (e_mwe[cyc]) gold[e_maddr[cyc]] = e_wold[cyc];
      e_men[cyc] = 0; e_mwe[cyc] = 0;
      e_dv[cyc] = 0; e_pv[cyc] = 0;
      e_dv[cyc+1] = 0; e_pv[cyc+1] = 0;
      dg = 0; pg = 0;
    end else begin
      pg = proc_req && (wait_m == LIM || !disp_req);
      dg = disp_req && !pg;
    end

    check_val("disp_gnt", disp_gnt, dg);
    check_val("proc_gnt", proc_gnt, pg);
    check_val("mem_en", mem_en, e_men[cyc]);
    check_val("mem_we", mem_we, e_mwe[cyc]);
    if (e_men[cyc]) check_val("mem_addr", mem_addr, e_maddr[cyc]);
    if (e_mwe[cyc]) check_val("mem_wdata", mem_wdata, e_mwd[cyc]);
    check_val("disp_rvalid", disp_rvalid, e_dv[cyc]);
    if (e_dv[cyc]) check_val("disp_rdata", disp_rdata, e_dd[cyc]);
    check_val("proc_rvalid", proc_rvalid, e_pv[cyc]);
    if (e_pv[cyc]) check_val("proc_rdata", proc_rdata, e_pd[cyc]);
    check_val("starve_cnt_max", starve_cnt_max, smax_m);

    if (reset) begin
      wait_m = 0;
      smax_m = 0;
    end else begin
      if (wait_m > smax_m) smax_m = (wait_m > 255) ? 255 : wait_m;
      if (!proc_req || pg) wait_m = 0;
      else if (wait_m < LIM) wait_m++;
      if (dg) begin
        e_men[cyc+1] = 1; e_maddr[cyc+1] = disp_addr;
        e_dv[cyc+2] = 1;  e_dd[cyc+2] = gold[disp_addr];
      end
      if (pg) begin
        e_men[cyc+1] = 1; e_maddr[cyc+1] = proc_addr;
        if (proc_we) begin
          e_mwe[cyc+1] = 1; e_mwd[cyc+1] = proc_wdata;
          e_wold[cyc+1] = gold[proc_addr];
          gold[proc_addr] = proc_wdata;
        end else begin
          e_pv[cyc+2] = 1; e_pd[cyc+2] = gold[proc_addr];
        end
      end
    end
    last_dg = dg;
    last_pg = pg;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    disp_req = 0;
    proc_req = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int dprob;
    for (int i = 0; i < MSZ; i++) begin
      bram[i] = 8'(i);
      gold[i] = 8'(i);
    end
    bram[100] = 8'h5A;
    gold[100] = 8'h5A;
    for (int i = 0; i <= MAXC + 3; i++) begin
      e_men[i] = 0; e_mwe[i] = 0; e_dv[i] = 0; e_pv[i] = 0;
      e_maddr[i] = '0; e_mwd[i] = '0; e_wold[i] = '0; e_dd[i] = '0; e_pd[i] = '0;
    end

    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 3; i++) tick();
    reset = 0;
    #1;
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_disp_rdata", disp_rdata, 0);
    check_val("rst_proc_rdata", proc_rdata, 0);

    // display only, addresses 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      disp_req = 1;
      disp_addr = AW'(i);
      tick();
    end
    idle(3);

    // contention: display wins, processing follows when display drops
    disp_req = 1; disp_addr = 14'd10;
    proc_req = 1; proc_we = 0; proc_addr = 14'd7;
    tick();
    disp_req = 0;
    tick();
    idle(3);

    // starvation: continuous display traffic, processing read of addr 100
    disp_req = 1; disp_addr = 14'd40;
    proc_req = 1; proc_we = 0; proc_addr = 14'd100;
    n = 0;
    last_pg = 0;
    while (!last_pg && n < 40) begin
      tick();
      n++;
      if (last_dg) disp_addr = AW'($urandom_range(0, 63));
    end
    check_val("starve_grant_cycle", n, LIM + 1);
    proc_req = 0;
    idle(3);
    check_val("starve_peak", starve_cnt_max, LIM);

    // write then read the same address
    proc_req = 1; proc_we = 1; proc_addr = 14'd5; proc_wdata = 8'hC3;
    tick();
    proc_we = 0;
    tick();
    idle(3);

    // reset the cycle after a display grant, then request right away
    disp_req = 1; disp_addr = 14'd20;
    tick();
    disp_req = 0;
    reset = 1;
    tick();
    reset = 0;
    disp_req = 1; disp_addr = 14'd21;
    tick();
    idle(3);

    // randomized traffic with occasional resets and varying display load
    dprob = 70;
    for (int k = 0; k < 2500; k++) begin
      if (k % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: dprob = 30;
          1: dprob = 70;
          default: dprob = 100;
        endcase
      end
      reset = ($urandom_range(0, 299) == 0);
      if (!disp_req || last_dg) begin
        disp_req = ($urandom_range(0, 99) < dprob);
        disp_addr = AW'($urandom_range(0, 31));
      end
      if (!proc_req || last_pg) begin
        proc_req = ($urandom_range(0, 99) < 40);
        proc_we = 1'($urandom_range(0, 1));
        proc_addr = AW'($urandom_range(0, 31));
        proc_wdata = DW'($urandom_range(0, 255));
      end
      tick();
    end
    reset = 0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, frame buffer address width (128x128 pixels).
REQ-002 Parameter DATA_W, default 8, gray pixel width.
REQ-003 Parameter STARVE_LIM, default 32, processing-port wait cycles before a forced slot.
REQ-004 clock  in  1  single clock; all logic is on the posedge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 disp_req  in  1  display read request; held until disp_gnt.
REQ-007 disp_addr  in  ADDR_W  display read address.
REQ-008 disp_gnt  out  1  display request accepted this cycle.
REQ-009 disp_rdata  out  DATA_W  display read data.
REQ-010 disp_rvalid  out  1  disp_rdata valid.
REQ-011 proc_req  in  1  processing request; held with its fields stable until proc_gnt.
REQ-012 proc_we  in  1  1 = write, 0 = read.
REQ-013 proc_addr  in  ADDR_W  processing address.
REQ-014 proc_wdata  in  DATA_W  processing write data.
REQ-015 proc_gnt  out  1  processing request accepted this cycle.
REQ-016 proc_rdata  out  DATA_W  processing read data.
REQ-017 proc_rvalid  out  1  proc_rdata valid (reads only).
REQ-018 mem_en  out  1  single-port BRAM enable.
REQ-019 mem_we  out  1  BRAM write enable.
REQ-020 mem_addr  out  ADDR_W  BRAM address.
REQ-021 mem_wdata  out  DATA_W  BRAM write data.
REQ-022 mem_rdata  in  DATA_W  BRAM read data; 1-cycle latency after mem_en.
REQ-023 starve_cnt_max  out  8  saturating peak processing wait, for debug.

Function
REQ-024 The arbiter SHALL accept at most one request per cycle.
- disp_gnt and proc_gnt are combinational and mutually exclusive.
REQ-025 Normal priority SHALL be display over processing.
REQ-026 A processing request SHALL be forced when the wait counter equals STARVE_LIM.
- proc_gnt=1 and disp_gnt=0 in that cycle, even if disp_req=1.
REQ-027 Wait counter SHALL increment each cycle proc_req=1 and proc_gnt=0.
- Clears on proc_gnt or proc_req=0.
- Saturates at STARVE_LIM.
REQ-028 starve_cnt_max SHALL track the peak wait value, saturating at 255; cleared only by reset.
REQ-029 An accepted request in cycle N SHALL drive registered mem_en/mem_we/mem_addr/mem_wdata during cycle N+1.
- mem_en=0 and mem_we=0 in every cycle following a cycle with no acceptance.
REQ-030 Read data SHALL return in cycle N+2, routed by a registered source tag.
- Display read: disp_rvalid=1 and disp_rdata=mem_rdata.
- Processing read: proc_rvalid=1 and proc_rdata=mem_rdata.
- Each rvalid is a one-cycle pulse.
REQ-031 Processing writes SHALL produce no rvalid.
REQ-032 Read data SHALL return in acceptance order with no reordering; back-to-back grants every cycle SHALL be supported.
REQ-033 State machine SHALL have states IDLE, DISP, PROC, recording the last accepted source.
- IDLE when nothing is accepted.
- DISP/PROC on the respective grant.
- Next state is a function of the current grant only.
REQ-034 A write followed by a read to the same address SHALL return the written data.
- Guaranteed by in-order issue to the single port; no bypass is required.

Reset
REQ-035 While reset=1, all grants, mem_en, mem_we, disp_rvalid and proc_rvalid SHALL be 0.
REQ-036 Reset values:
- mem_addr, mem_wdata, disp_rdata, proc_rdata = 0.
- Wait counter = 0, starve_cnt_max = 0, state = IDLE.
REQ-037 Reset mid-operation SHALL discard in-flight reads; no rvalid is issued for them after reset deasserts.
REQ-038 Requests SHALL be eligible for grant in the first cycle after reset deasserts.

Structure
REQ-039 Shared package fb_arb_pkg SHALL hold:
- ADDR_W and DATA_W defaults.
- STARVE_LIM default.
- State encoding (IDLE=0, DISP=1, PROC=2).
- Source tag encoding (NONE, DISP, PROC).
REQ-040 Sub-module fb_rd_return_pipe SHALL hold the registered tag pipeline and the rdata/rvalid steering.
REQ-041 Arbitration, counters and the state machine SHALL stay in the top module.

Verification
REQ-042 Display only: disp_req=1 for 4 cycles at addr 0..3, with BRAM preloaded with data=addr.
- disp_gnt=1 on each cycle.
- disp_rvalid for data 0,1,2,3 in 4 consecutive cycles, starting 2 cycles after the first grant.
REQ-043 Contention: disp_req=1 and proc_req=1 in the same cycle.
- disp_gnt=1 and proc_gnt=0.
- proc_gnt follows in the first cycle with disp_req=0.
REQ-044 Starvation: disp_req=1 continuously and proc_req=1 (read addr 100, data 0x5A).
- proc_gnt at wait count 32.
- proc_rdata=0x5A two cycles later.
- starve_cnt_max=32.
REQ-045 Write/read sequence: proc write addr 5=0xC3, then proc read addr 5.
- proc_rvalid with 0xC3.
- No rvalid for the write.
REQ-046 Reset mid-operation: reset pulsed the cycle after a display grant.
- No disp_rvalid for that read.
- All outputs 0; state IDLE.
- The next request is granted immediately after reset deasserts.
